// File: rtl/unified_ram_ctrl.sv
// Unified big-endian byte-addressed RAM with fetch, data and image-load ports.
// Define RAM_ZERO_INIT_EN to clear the array one word per cycle after every reset.
module unified_ram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 512,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  input  logic              mem_en,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_fault,
  output logic              busy
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_LOAD} state_t;
`ifdef RAM_ZERO_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
  localparam int WORDS  = DEPTH_BYTES / BYTES;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  logic [WCNT_W-1:0] init_cnt;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t state, state_nxt;
  logic [7:0] mem [DEPTH_BYTES];

  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return BYTES;
    endcase
  endfunction

  // Alignment plus range check; the extra address bit keeps addr+size from wrapping.
  function automatic logic access_ok(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic aligned;
    logic [ADDR_W:0] end_addr;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr % ADDR_W'(BYTES)) == '0;
      default: aligned = 1'b0;
    endcase
    end_addr = {1'b0, addr} + (ADDR_W+1)'(size_bytes(size));
    return aligned && (end_addr <= (ADDR_W+1)'(DEPTH_BYTES));
  endfunction

  logic [IDX_W-1:0]  if_idx, mem_idx, load_idx;
  logic              if_ok, data_ok, load_ok, load_fire, load_we, data_we;
  logic [DATA_W-1:0] fetch_word, data_word, read_val;
  int                data_n;

  assign if_idx     = if_addr[IDX_W-1:0];
  assign mem_idx    = mem_addr[IDX_W-1:0];
  assign load_idx   = load_addr[IDX_W-1:0];
  assign if_ok      = access_ok(if_addr, 2'b10);
  assign data_ok    = access_ok(mem_addr, mem_size);
  assign load_ok    = access_ok(load_addr, 2'b10);
  assign load_ready = (state == ST_LOAD);
  assign load_fire  = load_valid && load_ready;
  assign load_we    = load_fire && load_ok;
  assign data_we    = (state == ST_RUN) && mem_en && !mem_rw && data_ok;
  assign busy       = (state != ST_RUN);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fetch_word = '0;
    data_word  = '0;
    for (int i = 0; i < BYTES; i++) begin
      fetch_word[DATA_W-1-8*i -: 8] = mem[if_idx + IDX_W'(i)];
      data_word[DATA_W-1-8*i -: 8]  = mem[mem_idx + IDX_W'(i)];
    end
    data_n = size_bytes(mem_size);
    case (mem_size)
      2'b00:   read_val = DATA_W'(data_word[DATA_W-1 -: 8]);
      2'b01:   read_val = DATA_W'(data_word[DATA_W-1 -: 16]);
      default: read_val = data_word;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef RAM_ZERO_INIT_EN
      ST_INIT: if (init_cnt == WCNT_W'(WORDS - 1)) state_nxt = ST_RUN;
`endif
      ST_RUN:  if (load_mode)  state_nxt = ST_LOAD;
      ST_LOAD: if (!load_mode) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_nxt;
  end

`ifdef RAM_ZERO_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    else                       init_cnt <= '0;
  end
`endif

  // NOTE: the storage array has no reset so contents survive rst_n; INIT clears it explicitly.
  always_ff @(posedge clk) begin
`ifdef RAM_ZERO_INIT_EN
    if (state == ST_INIT)
      for (int i = 0; i < BYTES; i++) mem[IDX_W'(int'(init_cnt) * BYTES + i)] <= '0;
`endif
    if (load_we)
      for (int i = 0; i < BYTES; i++) mem[load_idx + IDX_W'(i)] <= load_data[DATA_W-1-8*i -: 8];
    if (data_we)
      for (int i = 0; i < BYTES; i++)
        if (i < data_n) mem[mem_idx + IDX_W'(i)] <= 8'(mem_wdata >> (8 * (data_n - 1 - i)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr   <= '0;
      if_valid   <= 1'b0;
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      if_valid   <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_fault  <= 1'b0;
      if (state == ST_RUN) begin
        if (if_en) begin
          if_valid <= 1'b1;
          if_instr <= if_ok ? fetch_word : '0;
          if (!if_ok) mem_fault <= 1'b1;
        end
        if (mem_en) begin
          if (!data_ok) begin
            mem_rdata  <= '0;
            mem_rvalid <= mem_rw;
            mem_fault  <= 1'b1;
          end else if (mem_rw) begin
            mem_rdata  <= read_val;
            mem_rvalid <= 1'b1;
          end
        end
      end else if (state == ST_LOAD && load_fire && !load_ok) begin
        mem_fault <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_unified_ram_ctrl.sv
// Scoreboard bench for unified_ram_ctrl: directed and random traffic checked
// against a byte-array model of the memory; a monitor pops expectations on DUT output.
module tb_unified_ram_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 32;
  localparam int WORDS  = DEPTH / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_mode = 1'b0, load_valid = 1'b0, load_ready;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              if_en = 1'b0, if_valid;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_instr;
  logic              mem_en = 1'b0, mem_rw = 1'b0, mem_rvalid, mem_fault, busy;
  logic [1:0]        mem_size = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0, mem_rdata;

  unified_ram_ctrl #(.DATA_W(DATA_W), .DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_mode(load_mode), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .if_en(if_en), .if_addr(if_addr), .if_instr(if_instr), .if_valid(if_valid),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_fault(mem_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          if_v;
    logic [31:0] instr;
    bit          chk_rv;
    bit          rv;
    bit          chk_rd;
    logic [31:0] rd;
    bit          fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model [DEPTH];
  bit          in_load;
  logic [31:0] last_rd;
  bit          rd_known;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte array, big-endian, sizes in bytes.
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_ok(input logic [31:0] a, input logic [1:0] s);
    longint la;
    la = longint'({32'd0, a});
    if (s == 2'b11) return 1'b0;
    if (la % nbytes(s) != 0) return 1'b0;
    return (la + nbytes(s)) <= DEPTH;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nbytes(s); i++) v = (v << 8) | {24'd0, model[a + i]};
    return v;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) model[a + i] = 8'(d >> (8 * (nbytes(s) - 1 - i)));
  endtask

  // One clock of stimulus: predict the response, queue it, apply inputs, step past the edge.
  task automatic drive(input bit lm, input bit lv, input logic [31:0] la, input logic [31:0] ld,
                       input bit ie, input logic [31:0] ia,
                       input bit me, input bit mrw, input logic [1:0] ms,
                       input logic [31:0] ma, input logic [31:0] mw);
    exp_t e;
    bit   ev;
    e  = '{if_v:1'b0, instr:'0, chk_rv:1'b1, rv:1'b0, chk_rd:1'b0, rd:'0, fault:1'b0};
    ev = 1'b0;
    check("load_ready", 32'(load_ready), 32'(in_load));
    check("busy", 32'(busy), 32'(in_load));
    if (in_load) begin
      if (lv) begin
        if (m_ok(la, 2'b10)) m_write(la, 2'b10, ld);
        else begin ev = 1'b1; e.fault = 1'b1; rd_known = 1'b0; end
      end
      if (!lm) in_load = 1'b0;
    end else begin
      if (ie) begin
        ev = 1'b1;
        e.if_v = 1'b1;
        if (m_ok(ia, 2'b10)) e.instr = m_read(ia, 2'b10);
        else begin e.fault = 1'b1; rd_known = 1'b0; end
      end
      if (me) begin
        if (!m_ok(ma, ms)) begin
          ev = 1'b1; e.fault = 1'b1; e.chk_rd = 1'b1; e.rd = '0;
          if (mrw) e.chk_rv = 1'b0;
          last_rd = '0; rd_known = 1'b1;
        end else if (mrw) begin
          ev = 1'b1; e.rv = 1'b1; e.chk_rd = 1'b1; e.rd = m_read(ma, ms);
          last_rd = e.rd; rd_known = 1'b1;
        end else begin
          m_write(ma, ms, mw);
        end
      end
      if (lm) in_load = 1'b1;
    end
    if (ev) begin
      if (!e.chk_rd && rd_known) begin e.chk_rd = 1'b1; e.rd = last_rd; end
      exp_q.push_back(e);
    end
    load_mode = lm; load_valid = lv; load_addr = la; load_data = ld;
    if_en = ie; if_addr = ia;
    mem_en = me; mem_rw = mrw; mem_size = ms; mem_addr = ma; mem_wdata = mw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask
  task automatic fetch(input logic [31:0] a);
    drive(1'b0, 1'b0, '0, '0, 1'b1, a, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask
  task automatic dread(input logic [31:0] a, input logic [1:0] s);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, s, a, '0);
  endtask
  task automatic dwrite(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, s, a, d);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'($urandom_range(DEPTH - 4, DEPTH + 8));
      1:       a = $urandom;
      default: begin
        a = 32'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
      end
    endcase
    return a;
  endfunction

  task automatic check_reset_outputs();
    check("rst_if_instr", if_instr, '0);
    check("rst_if_valid", 32'(if_valid), '0);
    check("rst_mem_rdata", mem_rdata, '0);
    check("rst_mem_rvalid", 32'(mem_rvalid), '0);
    check("rst_mem_fault", 32'(mem_fault), '0);
    check("rst_load_ready", 32'(load_ready), '0);
`ifdef RAM_ZERO_INIT_EN
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
  endtask

  // Leaves reset (and INIT, if built in) and resynchronises the model's mode.
  task automatic release_reset();
    int n;
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef RAM_ZERO_INIT_EN
    n = 0;
    while (busy && n < 4 * WORDS) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_cycles", 32'(n), 32'(WORDS));
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`else
    n = 0;
`endif
    in_load = 1'b0; last_rd = '0; rd_known = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (if_valid || mem_rvalid || mem_fault)) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", {29'd0, if_valid, mem_rvalid, mem_fault}, '0);
      end else begin
        e = exp_q.pop_front();
        check("if_valid", 32'(if_valid), 32'(e.if_v));
        if (e.if_v)   check("if_instr", if_instr, e.instr);
        if (e.chk_rv) check("mem_rvalid", 32'(mem_rvalid), 32'(e.rv));
        if (e.chk_rd) check("mem_rdata", mem_rdata, e.rd);
        check("mem_fault", 32'(mem_fault), 32'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, d2;
    bit          lm, lv, ie, me, mrw;
    logic [1:0]  ms;
    in_load = 1'b0; last_rd = '0; rd_known = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();

    // Image load: fill every word, with gaps, ignored port traffic and two bad beats.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    for (int w = 0; w < WORDS; w++) begin
      d = $urandom;
      if (w * 4 == 'h10) d = 32'h12345678;
      if (w * 4 == 'h14) d = 32'hDEADBEEF;
      if ($urandom_range(0, 3) == 0)
        drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h10, 1'b1, 1'b1, 2'b10, 32'h14, '0);
      if (w == 50) begin
        drive(1'b1, 1'b1, 32'h22, $urandom, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 1'b1, 32'h200, $urandom, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
      end
      drive(w != WORDS - 1, 1'b1, 32'(w * 4), d, 1'($urandom_range(0, 1)), 32'h8,
            1'($urandom_range(0, 1)), 1'b1, 2'b10, 32'h4, '0);
    end

    // Directed accesses.
    fetch(32'h10);
    dwrite(32'h11, 2'b00, 32'h000000AB);
    dread(32'h10, 2'b10);
    dread(32'h13, 2'b00);
    dread(32'h14, 2'b01);
    dread(32'h12, 2'b10);
    dwrite(32'h15, 2'b01, 32'h0000FFFF);
    dread(32'h10, 2'b11);
    dread(32'h1FE, 2'b10);
    dread(32'h10, 2'b10);
    dread(32'h14, 2'b10);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h10, 1'b1, 1'b0, 2'b10, 32'h10, 32'hCAFEF00D);
    fetch(32'h10);
    fetch(32'h1FC);
    fetch(32'h200);
    dread(32'h1FF, 2'b00);
    dread(32'h1FF, 2'b01);
    idle();
    idle();
    check("queue_drained_directed", 32'(exp_q.size()), '0);

    // Random traffic, including short load bursts.
    for (int n = 0; n < 400; n++) begin
      lm  = in_load ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 19) == 0);
      lv  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      me  = 1'($urandom_range(0, 1));
      mrw = 1'($urandom_range(0, 1));
      ms  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      d   = ($urandom_range(0, 7) == 0) ? rand_addr() : {23'd0, 7'($urandom_range(0, WORDS - 1)), 2'b00};
      drive(lm, lv, d, $urandom, ie, rand_addr(), me, mrw, ms, rand_addr(), $urandom);
    end
    if (in_load) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);

    // Reset in the middle of a two-beat load.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h10, 1'b1, 1'b1, 2'b10, 32'h14, '0);
    idle();
    idle();
    check("queue_drained_random", 32'(exp_q.size()), '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    d = $urandom;
    drive(1'b1, 1'b1, 32'h40, d, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    d2 = $urandom;
    load_mode = 1'b1; load_valid = 1'b1; load_addr = 32'h44; load_data = d2;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    load_mode = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    @(posedge clk);
    #1;
    release_reset();
    dread(32'h40, 2'b10);
    dread(32'h44, 2'b10);
    fetch(32'h40);
    for (int n = 0; n < 100; n++)
      drive(1'b0, 1'b0, '0, '0, 1'($urandom_range(0, 1)), rand_addr(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            rand_addr(), $urandom);
    idle();
    idle();
    idle();
    check("queue_drained_final", 32'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unified_ram_ctrl.md
Name: unified_ram_ctrl

Overview:
- Parametrised, fully synchronous, byte-addressed, big-endian unified memory for the pipelined CPU.
- One instruction-fetch port (F stage) and one data port (M stage) with byte/half/word access.
- Program-image load port with a valid/ready handshake, mode FSM, registered one-cycle-latency reads and alignment/range fault reporting.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8, at least 16.
- DEPTH_BYTES, 512, memory size in bytes; multiple of DATA_W/8.
- ADDR_W, 32, width of all address ports.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_mode  input  1  1 requests image-load mode.
- load_valid  input  1  load beat valid.
- load_ready  output  1  load beat accepted when valid&&ready.
- load_addr  input  ADDR_W  byte address of load word; must be word-aligned.
- load_data  input  DATA_W  load word, MSB byte at load_addr.
- if_en  input  1  fetch request.
- if_addr  input  ADDR_W  fetch byte address (PC).
- if_instr  output  DATA_W  fetched word, registered.
- if_valid  output  1  if_instr valid this cycle.
- mem_en  input  1  data access enable, from control.
- mem_rw  input  1  1 = read, 0 = write (control convention).
- mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_addr  input  ADDR_W  data byte address.
- mem_wdata  input  DATA_W  store data, right-aligned.
- mem_rdata  output  DATA_W  load data, right-aligned, zero-extended.
- mem_rvalid  output  1  mem_rdata valid this cycle.
- mem_fault  output  1  one-cycle pulse: misaligned, out-of-range or reserved access.
- busy  output  1  high whenever state != RUN.

Behaviour:
- Reset (async, rst_n low): if_instr=0, if_valid=0, mem_rdata=0, mem_rvalid=0, mem_fault=0, load_ready=0. State=INIT with RAM_ZERO_INIT_EN, else RUN. busy follows state. Array contents are not reset.
- States and transitions:
  - INIT: clears one word per cycle; goes to RUN after DEPTH_BYTES/(DATA_W/8) cycles.
  - RUN: goes to LOAD when load_mode=1.
  - LOAD: goes to RUN when load_mode=0. A beat presented in the same cycle is still accepted.
- LOAD: load_ready=1.
  - Each accepted beat writes load_data big-endian at load_addr.
  - Misaligned or out-of-range beat: nothing written, mem_fault pulses next cycle.
  - Fetch and data ports are ignored: if_valid=0, mem_rvalid=0.
- Fetch (RUN): if_en sampled at edge N gives if_instr and if_valid=1 at edge N+1. if_addr must be word-aligned and in range; otherwise if_instr=0, if_valid=1, mem_fault pulses.
- Data read (RUN, mem_en=1, mem_rw=1): one-cycle latency, same timing as fetch. Byte/half data is zero-extended into the LSBs.
- Data write (RUN, mem_en=1, mem_rw=0): commits at the edge.
  - Byte writes mem_wdata[7:0] at addr.
  - Half writes [15:8] at addr and [7:0] at addr+1.
  - Word writes MSB first.
  - mem_rvalid stays 0.
- Alignment rule: half needs addr[0]=0; word needs addr mod (DATA_W/8)=0. Range rule: addr+size_bytes <= DEPTH_BYTES.
- On any violation: no write, mem_rdata=0, mem_fault=1 for exactly one cycle after the request.
- Same-edge fetch and write to overlapping bytes: fetch returns the old data (read-before-write). The next cycle's read sees the new data.
- mem_en=0: outputs hold their last data; valid flags go to 0.
- Reset during LOAD or INIT: FSM restarts. Bytes written so far are retained (INIT restarts clearing from word 0).

Optional Feature:
- Macro RAM_ZERO_INIT_EN.
- Defined: after reset the FSM enters INIT, zeroes the whole array at one word/cycle with busy=1 and ignores all ports, then enters RUN.
- Undefined: no INIT state; reset goes directly to RUN and array contents are undefined until loaded.

Test Plan:
- Load 0x12345678 at 0x10 and 0xDEADBEEF at 0x14 via handshake, then fetch 0x10 -> if_instr=0x12345678 with if_valid one cycle after if_en.
- Byte write 0xAB at 0x11, then word read 0x10 -> 0x12AB5678; byte read 0x13 -> 0x00000078; half read 0x14 -> 0x0000DEAD.
- Word read at 0x12, half write at 0x15, mem_size=11, and word read at 0x1FE -> each gives a one-cycle mem_fault, no memory change, mem_rdata=0.
- Same-edge fetch at 0x10 and word write 0xCAFEF00D at 0x10 -> if_instr=0x12AB5678; fetch next cycle -> 0xCAFEF00D.
- Drop rst_n mid-LOAD after 1 of 2 beats -> outputs zero immediately, busy per macro, first beat's word retained (macro off).
- With RAM_ZERO_INIT_EN: after reset busy=1 for 128 cycles (defaults), then a read of any address -> 0.
